// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit
//
// Arbiter and command-bus multiplexer for the single-chip SDRAM controller.
// It hands the SDRAM pins to one of the init, auto-refresh, write or read
// sub-modules at a time. The handshake has three parts:
//   - the client raises its request;
//   - the arbiter answers with a one-cycle enable;
//   - the client owns the bus until it pulses its end flag.
// Refresh beats write/read. Write and read alternate on a tie.
// A grant that never ends is forced back to idle after TIMEOUT busy cycles,
// and the sticky arb_err flag is set when that happens.
//
// Parameters:
//   TIMEOUT  max busy cycles for a grant without its end flag
//   CMD_NOP  {cs_n,ras_n,cas_n,we_n} idle command
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   init_cmd/addr, flag_init_end   init block command bus and done flag
//   ref_req/en, flag_ref_end       refresh handshake
//   ref_cmd/addr                   refresh command bus
//   wr_req/en, flag_wr_end         write handshake
//   wr_cmd/addr/bank/data          write command bus and write data
//   rd_req/en, flag_rd_end         read handshake
//   rd_cmd/addr/bank               read command bus
//   sdram_*                        SDRAM pins (cke, command, bank, addr, dq)
//   arb_err                        sticky timeout flag
// ---------------------------------------------------------------------------
module sdram_arbit #(
  parameter int          TIMEOUT = 1023,
  parameter logic [3:0]  CMD_NOP = 4'b0111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        flag_init_end,
  input  logic        ref_req,
  output logic        ref_en,
  input  logic        flag_ref_end,
  input  logic [3:0]  ref_cmd,
  input  logic [11:0] ref_addr,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic [15:0] wr_data,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_bank,
  output logic [11:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic        arb_err
);

  typedef enum logic [4:0] {
    ARB_INIT  = 5'b00001,
    ARB_IDLE  = 5'b00010,
    ARB_AREF  = 5'b00100,
    ARB_WRITE = 5'b01000,
    ARB_READ  = 5'b10000
  } arb_state_t;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The counter starts at 0 in the first busy cycle.
  // A value of TIMEOUT-1 therefore marks the TIMEOUT-th busy cycle.
  localparam logic [CW-1:0] BUSY_LAST = CW'(TIMEOUT - 1);

  arb_state_t    state, state_next;
  grant_t        last_grant, last_grant_next;
  logic [CW-1:0] busy_cnt;
  logic          timeout_hit;
  logic          err_set;
  logic          busy_now, busy_stay;
  logic [3:0]    sel_cmd;

  assign timeout_hit = (busy_cnt == BUSY_LAST);
  assign busy_now    = (state == ARB_AREF) || (state == ARB_WRITE) || (state == ARB_READ);
  assign busy_stay   = busy_now && (state_next == state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_INIT;
      last_grant <= GRANT_READ;
      busy_cnt   <= '0;
      arb_err    <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      // The counter clears whenever a grant ends.
      // So every new grant starts counting from zero.
      busy_cnt   <= busy_stay ? busy_cnt + 1'b1 : '0;
      if (err_set)
        arb_err <= 1'b1;
    end
  end

  // Grant decision and state transitions.
  // Enables are only raised in the single IDLE cycle that picks a winner.
  // This guarantees a NOP cycle between any two grants.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    ref_en          = 1'b0;
    wr_en           = 1'b0;
    rd_en           = 1'b0;
    err_set         = 1'b0;
    case (state)
      ARB_INIT: begin
        if (flag_init_end)
          state_next = ARB_IDLE;
      end
      ARB_IDLE: begin
        if (ref_req) begin
          ref_en     = 1'b1;
          state_next = ARB_AREF;
        end else if (wr_req && (!rd_req || last_grant == GRANT_READ)) begin
          wr_en           = 1'b1;
          state_next      = ARB_WRITE;
          last_grant_next = GRANT_WRITE;
        end else if (rd_req) begin
          rd_en           = 1'b1;
          state_next      = ARB_READ;
          last_grant_next = GRANT_READ;
        end
      end
      // In the busy states, an end flag takes precedence over a timeout.
      // If both arrive together, the grant finishes normally.
      ARB_AREF: begin
        if (flag_ref_end) begin
          state_next = ARB_IDLE;
        end else if (timeout_hit) begin
          state_next = ARB_IDLE;
          err_set    = 1'b1;
        end
      end
      ARB_WRITE: begin
        if (flag_wr_end) begin
          state_next = ARB_IDLE;
        end else if (timeout_hit) begin
          state_next = ARB_IDLE;
          err_set    = 1'b1;
        end
      end
      ARB_READ: begin
        if (flag_rd_end) begin
          state_next = ARB_IDLE;
        end else if (timeout_hit) begin
          state_next = ARB_IDLE;
          err_set    = 1'b1;
        end
      end
      default: state_next = ARB_INIT;
    endcase
  end

  // Pin multiplexer.
  // While reset is held, the pins are forced idle without waiting for a clock.
  always_comb begin
    sel_cmd      = CMD_NOP;
    sdram_addr   = '0;
    sdram_bank   = '0;
    sdram_dq_out = '0;
    sdram_dq_oe  = 1'b0;
    if (rst_n) begin
      case (state)
        ARB_INIT: begin
          sel_cmd    = init_cmd;
          sdram_addr = init_addr;
        end
        ARB_AREF: begin
          sel_cmd    = ref_cmd;
          sdram_addr = ref_addr;
        end
        ARB_WRITE: begin
          sel_cmd      = wr_cmd;
          sdram_addr   = wr_addr;
          sdram_bank   = wr_bank;
          sdram_dq_out = wr_data;
          sdram_dq_oe  = 1'b1;
        end
        ARB_READ: begin
          sel_cmd    = rd_cmd;
          sdram_addr = rd_addr;
          sdram_bank = rd_bank;
        end
        default: ;
      endcase
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = sel_cmd;
  assign sdram_cke = 1'b1;

endmodule

// File: tb/tb_sdram_arbit.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbit
//
// Self-checking bench for sdram_arbit (built with TIMEOUT=15).
//
// Each cycle, inputs are driven on the falling edge. Outputs are then compared
// against a reference model that tracks three things:
//   - which client owns the bus;
//   - how many cycles that client has held it;
//   - which of write/read was granted last.
//
// Phases:
//   - init sequence
//   - saturated requests
//   - random traffic
//   - forced timeout
//   - more random traffic
//   - asynchronous reset in the middle of a write
//   - a second init sequence
// ---------------------------------------------------------------------------
module tb_sdram_arbit;

  localparam int         TIMEOUT = 15;
  localparam logic [3:0] NOP     = 4'b0111;

  localparam int OWN_INIT = 0;
  localparam int OWN_IDLE = 1;
  localparam int OWN_REF  = 2;
  localparam int OWN_WR   = 3;
  localparam int OWN_RD   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  init_cmd;
  logic [11:0] init_addr;
  logic        flag_init_end;
  logic        ref_req, ref_en, flag_ref_end;
  logic [3:0]  ref_cmd;
  logic [11:0] ref_addr;
  logic        wr_req, wr_en, flag_wr_end;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  wr_bank;
  logic [15:0] wr_data;
  logic        rd_req, rd_en, flag_rd_end;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_bank;
  logic [11:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic        arb_err;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  int m_owner;
  int m_busy;
  bit m_last_rd;
  bit m_err;

  sdram_arbit #(.TIMEOUT(TIMEOUT), .CMD_NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_cmd(init_cmd), .init_addr(init_addr), .flag_init_end(flag_init_end),
    .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
    .ref_cmd(ref_cmd), .ref_addr(ref_addr),
    .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
    .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_owner   = OWN_INIT;
    m_busy    = 0;
    m_last_rd = 1'b1;
    m_err     = 1'b0;
  endtask

  // Every output must sit at its idle value while reset is asserted.
  task automatic checkQuiet();
    checkOutput("rst_en",   {29'd0, ref_en, wr_en, rd_en}, 32'd0);
    checkOutput("rst_cmd",  {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, NOP});
    checkOutput("rst_addr", {20'd0, sdram_addr}, 32'd0);
    checkOutput("rst_bank", {30'd0, sdram_bank}, 32'd0);
    checkOutput("rst_dq",   {15'd0, sdram_dq_oe, sdram_dq_out}, 32'd0);
    checkOutput("rst_err",  {31'd0, arb_err}, 32'd0);
    checkOutput("rst_cke",  {31'd0, sdram_cke}, 32'd1);
  endtask

  // Stimulus modes:
  //   0 = init sequence (wr_req from cycle 5, init done at cycle 20)
  //   1 = random traffic
  //   2 = read only, never ended (forces a timeout)
  //   3 = every request and every end flag held high
  task automatic applyStimulus(input int mode, input int cyc);
    init_cmd  = 4'($urandom);
    init_addr = 12'($urandom);
    ref_cmd   = 4'($urandom);
    ref_addr  = 12'($urandom);
    wr_cmd    = 4'($urandom);
    wr_addr   = 12'($urandom);
    wr_bank   = 2'($urandom);
    wr_data   = 16'($urandom);
    rd_cmd    = 4'($urandom);
    rd_addr   = 12'($urandom);
    rd_bank   = 2'($urandom);
    flag_init_end = 1'b0;
    case (mode)
      0: begin
        init_cmd      = 4'b0010;
        init_addr     = 12'h400;
        ref_req       = 1'b0;
        rd_req        = 1'b0;
        wr_req        = (cyc >= 5);
        flag_init_end = (cyc == 20);
        flag_ref_end  = 1'b0;
        flag_wr_end   = (cyc >= 26);
        flag_rd_end   = 1'b0;
        wr_cmd        = 4'b0100;
        wr_addr       = 12'h005;
      end
      1: begin
        ref_req      = ($urandom_range(5) == 0);
        wr_req       = ($urandom_range(1) == 0);
        rd_req       = ($urandom_range(1) == 0);
        flag_ref_end = ($urandom_range(3) == 0);
        flag_wr_end  = ($urandom_range(3) == 0);
        flag_rd_end  = ($urandom_range(3) == 0);
      end
      2: begin
        ref_req      = 1'b0;
        wr_req       = 1'b0;
        rd_req       = 1'b1;
        flag_ref_end = 1'b0;
        flag_wr_end  = 1'b0;
        flag_rd_end  = 1'b0;
      end
      default: begin
        ref_req      = 1'b1;
        wr_req       = 1'b1;
        rd_req       = 1'b1;
        flag_ref_end = 1'b1;
        flag_wr_end  = 1'b1;
        flag_rd_end  = 1'b1;
      end
    endcase
  endtask

  // One clock cycle:
  //   - drive inputs on the falling edge;
  //   - compare outputs against the model;
  //   - advance the model to what the coming rising edge should produce.
  task automatic stepCycle(input int mode, input int cyc);
    logic [2:0]  e_en;
    logic [3:0]  e_cmd;
    logic [11:0] e_addr;
    logic [1:0]  e_bank;
    logic        e_oe;
    logic [15:0] e_dq;
    bit          ended;
    @(negedge clk);
    applyStimulus(mode, cyc);
    #1;
    e_en = 3'b000; e_cmd = NOP; e_addr = '0; e_bank = '0; e_oe = 1'b0; e_dq = '0;
    case (m_owner)
      OWN_INIT: begin e_cmd = init_cmd; e_addr = init_addr; end
      OWN_IDLE: begin
        if (ref_req)                        e_en = 3'b100;
        else if (wr_req && rd_req)          e_en = m_last_rd ? 3'b010 : 3'b001;
        else if (wr_req)                    e_en = 3'b010;
        else if (rd_req)                    e_en = 3'b001;
      end
      OWN_REF: begin e_cmd = ref_cmd; e_addr = ref_addr; end
      OWN_WR:  begin
        e_cmd = wr_cmd; e_addr = wr_addr; e_bank = wr_bank; e_oe = 1'b1; e_dq = wr_data;
      end
      default: begin e_cmd = rd_cmd; e_addr = rd_addr; e_bank = rd_bank; end
    endcase
    checkOutput("grant", {29'd0, ref_en, wr_en, rd_en}, {29'd0, e_en});
    checkOutput("cmd",   {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, e_cmd});
    checkOutput("addr",  {20'd0, sdram_addr}, {20'd0, e_addr});
    checkOutput("bank",  {30'd0, sdram_bank}, {30'd0, e_bank});
    checkOutput("dq",    {15'd0, sdram_dq_oe, sdram_dq_out}, {15'd0, e_oe, e_dq});
    checkOutput("err",   {31'd0, arb_err}, {31'd0, m_err});
    checkOutput("cke",   {31'd0, sdram_cke}, 32'd1);
    case (m_owner)
      OWN_INIT: if (flag_init_end) m_owner = OWN_IDLE;
      OWN_IDLE: begin
        m_busy = 0;
        if (e_en[2])      m_owner = OWN_REF;
        else if (e_en[1]) begin m_owner = OWN_WR; m_last_rd = 1'b0; end
        else if (e_en[0]) begin m_owner = OWN_RD; m_last_rd = 1'b1; end
      end
      default: begin
        m_busy++;
        ended = (m_owner == OWN_REF && flag_ref_end) ||
                (m_owner == OWN_WR  && flag_wr_end)  ||
                (m_owner == OWN_RD  && flag_rd_end);
        if (ended) begin
          m_owner = OWN_IDLE;
        end else if (m_busy >= TIMEOUT) begin
          m_owner = OWN_IDLE;
          m_err   = 1'b1;
        end
      end
    endcase
  endtask

  task automatic quietInputs();
    ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    flag_init_end = 1'b0; flag_ref_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
  endtask

  initial begin
    bit reached;
    rst_n = 1'b0;
    applyStimulus(3, 0);
    #3;
    modelReset();
    checkQuiet();
    repeat (3) @(posedge clk);
    @(negedge clk);
    quietInputs();
    rst_n = 1'b1;

    for (int c = 0; c < 40; c++)  stepCycle(0, c);
    for (int c = 0; c < 20; c++)  stepCycle(3, c);
    for (int c = 0; c < 300; c++) stepCycle(1, c);
    for (int c = 0; c < 40; c++)  stepCycle(2, c);
    checkOutput("timeout_err", {31'd0, arb_err}, 32'd1);
    for (int c = 0; c < 100; c++) stepCycle(1, c);
    checkOutput("err_sticky", {31'd0, arb_err}, 32'd1);

    // Walk until the model predicts WRITE after the next edge.
    reached = 1'b0;
    for (int c = 0; c < 500 && !reached; c++) begin
      stepCycle(1, c);
      if (m_owner == OWN_WR) reached = 1'b1;
    end
    if (!reached) begin
      checkOutput("reach_write", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #3;
      checkOutput("pre_rst_oe", {31'd0, sdram_dq_oe}, 32'd1);
      wr_req = 1'b1;
      rd_req = 1'b1;
      rst_n  = 1'b0;
      #1;
      modelReset();
      checkQuiet();
      repeat (2) @(posedge clk);
      @(negedge clk);
      quietInputs();
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) stepCycle(0, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Arbiter and command-bus multiplexer for the single-chip SDRAM controller.
- Sits between the init, auto-refresh, write and read sub-modules and the SDRAM pins.
- Grants the bus to one sub-module at a time using an enable/request/end-flag handshake.
- Drives the SDRAM command, address, bank and data lines from the granted sub-module.

Parameters:
- TIMEOUT, 1023: max cycles a grant may stay busy without its end flag before forced release.
- CMD_NOP, 4'b0111: {cs_n,ras_n,cas_n,we_n} idle command.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- init_cmd  input  4  command from init block
- init_addr  input  12  address from init block
- flag_init_end  input  1  init sequence complete (level or pulse)
- ref_req  input  1  refresh request
- ref_en  output  1  refresh grant
- flag_ref_end  input  1  refresh done pulse
- ref_cmd  input  4  command from refresh block
- ref_addr  input  12  address from refresh block
- wr_req  input  1  write request
- wr_en  output  1  write grant
- flag_wr_end  input  1  write done pulse
- wr_cmd  input  4  command from write block
- wr_addr  input  12  address from write block
- wr_bank  input  2  bank from write block
- wr_data  input  16  write data
- rd_req  input  1  read request
- rd_en  output  1  read grant
- flag_rd_end  input  1  read done pulse
- rd_cmd  input  4  command from read block
- rd_addr  input  12  address from read block
- rd_bank  input  2  bank from read block
- sdram_cke  output  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  output  1 each  command pins
- sdram_bank  output  2  bank pins
- sdram_addr  output  12  address pins
- sdram_dq_out  output  16  data to pad
- sdram_dq_oe  output  1  pad output enable
- arb_err  output  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n low):
  - state=ARB_INIT; last_grant=READ; busy counter=0; arb_err=0.
  - Outputs: ref_en/wr_en/rd_en=0, command pins=CMD_NOP, addr=0, bank=0, dq_out=0, dq_oe=0, sdram_cke=1.
- State machine (one-hot): ARB_INIT, ARB_IDLE, ARB_AREF, ARB_WRITE, ARB_READ.
- ARB_INIT:
  - Pins carry init_cmd/init_addr, bank=0.
  - Go to ARB_IDLE on flag_init_end=1.
  - All requests are ignored in this state.
- ARB_IDLE:
  - Pins carry CMD_NOP, addr=0.
  - Priority, evaluated each cycle: ref_req first, then wr_req/rd_req.
  - Write vs read tie: grant the one not equal to last_grant. Single request: grant it.
- Grant signalling:
  - ref_en/wr_en/rd_en are combinational, high only in the ARB_IDLE cycle where that grant is chosen, exactly 1 cycle wide.
  - The state moves to ARB_AREF/ARB_WRITE/ARB_READ on the same edge.
  - last_grant is updated on write/read grant only.
- ARB_AREF: pins carry ref_cmd/ref_addr, bank=0. Go to ARB_IDLE on flag_ref_end.
- ARB_WRITE:
  - Pins carry wr_cmd/wr_addr/wr_bank; dq_out=wr_data; dq_oe=1.
  - Go to ARB_IDLE on flag_wr_end.
- ARB_READ: pins carry rd_cmd/rd_addr/rd_bank; dq_oe=0. Go to ARB_IDLE on flag_rd_end.
- No preemption: ref_req during ARB_WRITE/ARB_READ is not acted on. The sub-module ends its burst and raises its end flag; refresh then wins in the following ARB_IDLE cycle.
- Minimum gap: at least one ARB_IDLE (NOP) cycle between any two grants. An end flag and a new request in the same cycle give IDLE next cycle, then the grant.
- Command pins {cs_n,ras_n,cas_n,we_n} are a combinational decode of the selected 4-bit cmd.
- Timeout:
  - The busy counter counts cycles in AREF/WRITE/READ and clears in IDLE/INIT.
  - On reaching TIMEOUT without an end flag: force ARB_IDLE and set arb_err=1 (cleared only by reset).
  - An end flag in the same cycle as the timeout counts as a normal end; arb_err stays unchanged.
- End flags for a non-granted client are ignored.
- Reset mid-grant: immediate return to reset values; enables deasserted.

Test Plan:
- Init: hold init_cmd=4'b0010, addr=12'h400, pulse flag_init_end at cycle 20 → pins follow init until cycle 20, NOP afterwards; wr_req asserted at cycle 5 is not granted before cycle 21.
- Write grant: wr_req=1 in IDLE → wr_en high exactly 1 cycle; next cycle wr_cmd=4'b0100/wr_addr=12'h005 appear on pins with dq_oe=1, dq_out=wr_data; flag_wr_end → NOP next cycle.
- Priority: ref_req, wr_req, rd_req all high in IDLE → ref_en only; after flag_ref_end, one IDLE cycle, then wr_en; after flag_wr_end, IDLE, then rd_en (alternation).
- Refresh during write: ref_req rises mid-ARB_WRITE → no ref_en until flag_wr_end; ref_en fires in the first IDLE cycle after it, ahead of a pending wr_req.
- Timeout with TIMEOUT=15: grant read, never pulse flag_rd_end → return to IDLE after 15 busy cycles, arb_err=1 and held through subsequent traffic.
- Async reset while in ARB_WRITE → pins NOP, dq_oe=0, enables 0, state ARB_INIT immediately without waiting for a clock edge.
